// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer -- microcode-free control sequencer for a 4-bit accumulator CPU
// FETCH -> DECODE -> EXEC -> WRITE per instruction, plus IDLE/HALT/PAUSE.
// Opcode map: 0000 HLT, 0001 ADD, 0010 SUB, 0011 STO, 0100 LD, 0101 B,
//             0110 BZ, 0111 LDV, 1000 INP, 1001 OUT, 1010 AND, 1011 OR,
//             1100 NOT, 1101-1111 illegal.
// Optional single-step support when CPU_SEQ_STEP_EN is defined
// (adds step_mode/step inputs and the PAUSE state).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       prog_mode,
`ifdef CPU_SEQ_STEP_EN
  input  logic       step_mode,
  input  logic       step,
`endif
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  output logic       pc_clr,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [1:0] b_sel,
  output logic [3:0] alu_s,
  output logic       alu_m,
  output logic       alu_cn,
  output logic       alureg_we,
  output logic       acc_we,
  output logic       ram_we,
  output logic       out_we,
  output logic       busy,
  output logic       halted,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4,
    S_HALT   = 3'd5,
    S_PAUSE  = 3'd6
  } state_t;

  localparam logic [3:0] OP_HLT = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_STO = 4'b0011;
  localparam logic [3:0] OP_LD  = 4'b0100;
  localparam logic [3:0] OP_B   = 4'b0101;
  localparam logic [3:0] OP_BZ  = 4'b0110;
  localparam logic [3:0] OP_LDV = 4'b0111;
  localparam logic [3:0] OP_INP = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1001;
  localparam logic [3:0] OP_AND = 4'b1010;
  localparam logic [3:0] OP_OR  = 4'b1011;
  localparam logic [3:0] OP_NOT = 4'b1100;

  state_t     state_q, state_d;
  logic [3:0] ir;
  logic       acc_op;   // instruction writes the accumulator through alureg

  assign state  = state_q;
  assign busy   = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                  (state_q == S_EXEC)  || (state_q == S_WRITE)  ||
                  (state_q == S_PAUSE);
  assign halted = (state_q == S_HALT);

  assign acc_op = (ir == OP_INP) || (ir == OP_ADD) || (ir == OP_SUB) ||
                  (ir == OP_LD)  || (ir == OP_LDV) || (ir == OP_AND) ||
                  (ir == OP_OR)  || (ir == OP_NOT);

  // State register; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Instruction register captures the opcode during FETCH only
  always_ff @(posedge clk) begin
    if (reset)                                   ir <= OP_HLT;
    else if (state_q == S_FETCH && !prog_mode)   ir <= opcode;
  end

  // Next-state, ALU controls and strobes
  always_comb begin
    state_d   = state_q;
    pc_clr    = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    alureg_we = 1'b0;
    acc_we    = 1'b0;
    ram_we    = 1'b0;
    out_we    = 1'b0;
    illegal   = 1'b0;
    alu_s     = 4'b0000;
    alu_m     = 1'b0;
    alu_cn    = 1'b1;
    b_sel     = 2'd0;

    // ALU setup is held steady across the three decode-driven states
    if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_WRITE) begin
      case (ir)
        OP_ADD: begin alu_s = 4'b1001; alu_m = 1'b0; alu_cn = 1'b0; b_sel = 2'd1; end
        OP_SUB: begin alu_s = 4'b0110; alu_m = 1'b0; alu_cn = 1'b1; b_sel = 2'd1; end
        OP_LD:  begin alu_s = 4'b1010; alu_m = 1'b1; alu_cn = 1'b0; b_sel = 2'd1; end
        OP_LDV: begin alu_s = 4'b1010; alu_m = 1'b1; alu_cn = 1'b0; b_sel = 2'd2; end
        OP_INP: begin alu_s = 4'b1010; alu_m = 1'b1; alu_cn = 1'b0; b_sel = 2'd3; end
        OP_AND: begin alu_s = 4'b1110; alu_m = 1'b1; alu_cn = 1'b0; b_sel = 2'd1; end
        OP_OR:  begin alu_s = 4'b1011; alu_m = 1'b1; alu_cn = 1'b0; b_sel = 2'd1; end
        OP_NOT: begin alu_s = 4'b0000; alu_m = 1'b1; alu_cn = 1'b0; b_sel = 2'd0; end
        default: ;  // STO/OUT/branches/illegal keep pass-through A
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_clr  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (ir == OP_HLT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        alureg_we = acc_op;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        acc_we  = acc_op;
        ram_we  = (ir == OP_STO);
        out_we  = (ir == OP_OUT);
        illegal = (ir >= 4'b1101);
        if ((ir == OP_B) || (ir == OP_BZ && acc_zero)) pc_load = 1'b1;
        else                                           pc_inc  = 1'b1;
`ifdef CPU_SEQ_STEP_EN
        state_d = step_mode ? S_PAUSE : S_FETCH;
`else
        state_d = S_FETCH;
`endif
      end
      S_HALT: begin
        if (start) begin
          pc_clr  = 1'b1;
          state_d = S_FETCH;
        end
      end
`ifdef CPU_SEQ_STEP_EN
      S_PAUSE: begin
        if (step) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Program-load mode aborts to IDLE; it and reset silence every strobe
    if (prog_mode) state_d = S_IDLE;
    if (reset || prog_mode) begin
      pc_clr    = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      alureg_we = 1'b0;
      acc_we    = 1'b0;
      ram_we    = 1'b0;
      out_we    = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer -- directed self-checking bench for cpu_sequencer
// Strobe vector order: {pc_clr,pc_inc,pc_load,alureg_we,acc_we,ram_we,out_we,illegal}
// ALU vector order:    {alu_s[3:0],alu_m,alu_cn,b_sel[1:0]}
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, prog_mode, acc_zero;
  logic [3:0] opcode;
`ifdef CPU_SEQ_STEP_EN
  logic       step_mode, step;
`endif
  logic       pc_clr, pc_inc, pc_load, alu_m, alu_cn;
  logic       alureg_we, acc_we, ram_we, out_we, busy, halted, illegal;
  logic [1:0] b_sel;
  logic [3:0] alu_s;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .prog_mode(prog_mode),
`ifdef CPU_SEQ_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .opcode(opcode), .acc_zero(acc_zero),
    .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_load(pc_load), .b_sel(b_sel),
    .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn), .alureg_we(alureg_we),
    .acc_we(acc_we), .ram_we(ram_we), .out_we(out_we), .busy(busy),
    .halted(halted), .illegal(illegal), .state(state)
  );

  wire [7:0] strb = {pc_clr, pc_inc, pc_load, alureg_we, acc_we, ram_we, out_we, illegal};
  wire [7:0] aluv = {alu_s, alu_m, alu_cn, b_sel};

  // Single comparison point for the whole bench
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1ns past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction starting in FETCH; opcode is scrambled after FETCH
  // so any decode that bypasses the instruction register shows up.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic az,
                           input logic [7:0] exec_v, input logic [7:0] write_v,
                           input logic [7:0] alu_v);
    opcode = op; acc_zero = az; #1;
    check({tag, ".fetch_state"}, state, 1);
    tick();
    opcode = ~op; #1;
    check({tag, ".decode_state"}, state, 2);
    check({tag, ".decode_alu"}, aluv, alu_v);
    check({tag, ".decode_strb"}, strb, 0);
    tick();
    check({tag, ".exec_state"}, state, 3);
    check({tag, ".exec_strb"}, strb, exec_v);
    tick();
    check({tag, ".write_state"}, state, 4);
    check({tag, ".write_strb"}, strb, write_v);
    check({tag, ".write_alu"}, aluv, alu_v);
    tick();
    check({tag, ".next_state"}, state, 1);
  endtask

  // Pulse start in IDLE/HALT and confirm pc_clr then FETCH
  task automatic do_start(input string tag);
    start = 1'b1; #1;
    check({tag, ".pc_clr"}, strb, 8'h80);
    tick();
    start = 1'b0; #1;
    check({tag, ".to_fetch"}, state, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; prog_mode = 1'b0; acc_zero = 1'b0; opcode = 4'h0;
`ifdef CPU_SEQ_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0; #1;
    check("rst.state", state, 0);
    check("rst.strb", strb, 0);
    check("rst.alu", aluv, 8'b0000_0_1_00);
    check("rst.flags", {busy, halted}, 0);

    // Basic ADD from start
    do_start("start1");
    check("fetch.busy", busy, 1);
    run_instr("add", 4'b0001, 1'b0, 8'h10, 8'h48, 8'b1001_0_0_01);
    run_instr("sub", 4'b0010, 1'b0, 8'h10, 8'h48, 8'b0110_0_1_01);
    run_instr("sto", 4'b0011, 1'b0, 8'h00, 8'h44, 8'b0000_0_1_00);
    run_instr("ld",  4'b0100, 1'b0, 8'h10, 8'h48, 8'b1010_1_0_01);
    run_instr("b",   4'b0101, 1'b0, 8'h00, 8'h20, 8'b0000_0_1_00);
    run_instr("bz1", 4'b0110, 1'b1, 8'h00, 8'h20, 8'b0000_0_1_00);
    run_instr("bz0", 4'b0110, 1'b0, 8'h00, 8'h40, 8'b0000_0_1_00);
    run_instr("ldv", 4'b0111, 1'b0, 8'h10, 8'h48, 8'b1010_1_0_10);
    run_instr("inp", 4'b1000, 1'b0, 8'h10, 8'h48, 8'b1010_1_0_11);
    run_instr("out", 4'b1001, 1'b0, 8'h00, 8'h42, 8'b0000_0_1_00);
    run_instr("and", 4'b1010, 1'b0, 8'h10, 8'h48, 8'b1110_1_0_01);
    run_instr("or",  4'b1011, 1'b0, 8'h10, 8'h48, 8'b1011_1_0_01);
    run_instr("not", 4'b1100, 1'b0, 8'h10, 8'h48, 8'b0000_1_0_00);
    run_instr("ill", 4'b1110, 1'b0, 8'h00, 8'h41, 8'b0000_0_1_00);
    run_instr("ild", 4'b1101, 1'b0, 8'h00, 8'h41, 8'b0000_0_1_00);

    // HLT: DECODE then HALT, quiet for 10 cycles
    opcode = 4'b0000; tick();
    check("hlt.decode", state, 2);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("hlt.state", state, 5);
      check("hlt.flags", {busy, halted}, 2'b01);
      check("hlt.strb", strb, 0);
      tick();
    end
    do_start("restart");

    // prog_mode in EXEC: no alureg_we/acc_we, then IDLE; wins over start
    opcode = 4'b0001; tick(); tick();
    check("pm.exec_state", state, 3);
    prog_mode = 1'b1; #1;
    check("pm.exec_strb", strb, 0);
    tick();
    check("pm.idle", state, 0);
    check("pm.idle_strb", strb, 0);
    start = 1'b1; #1;
    check("pm.start_strb", strb, 0);
    tick();
    check("pm.start_ignored", state, 0);
    start = 1'b0; prog_mode = 1'b0; #1;
    do_start("start2");

    // Reset during WRITE suppresses strobes and returns to IDLE
    opcode = 4'b0001; tick(); tick(); tick();
    check("rw.write_state", state, 4);
    reset = 1'b1; #1;
    check("rw.strb", strb, 0);
    tick();
    reset = 1'b0; #1;
    check("rw.idle", state, 0);
    check("rw.alu", aluv, 8'b0000_0_1_00);

`ifdef CPU_SEQ_STEP_EN
    // Single-step: WRITE -> PAUSE, hold, then step -> FETCH
    do_start("start3");
    step_mode = 1'b1; opcode = 4'b0001; tick(); tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("step.pause", state, 6);
      check("step.strb", strb, 0);
      check("step.busy", busy, 1);
      tick();
    end
    step = 1'b1; tick(); step = 1'b0; #1;
    check("step.fetch", state, 1);
    step_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have these ports (clock and reset first):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins execution from address 0
- prog_mode  in  1  program-load mode; aborts and holds sequencer idle
- opcode  in  4  instruction field of the instruction RAM at current PC
- acc_zero  in  1  high when accumulator == 0
- pc_clr / pc_inc / pc_load  out  1 each  PC clear, increment, branch-load strobes
- b_sel  out  2  ALU B mux: 0 zero, 1 system RAM, 2 data field, 3 external input
- alu_s  out  4  ALU function select
- alu_m  out  1  ALU mode
- alu_cn  out  1  ALU carry-in
- alureg_we / acc_we / ram_we / out_we  out  1 each  write strobes
- busy  out  1  high in FETCH, DECODE, EXEC, WRITE, PAUSE
- halted  out  1  high in HALT
- illegal  out  1  one-cycle pulse on unused opcode
- state  out  3  current state code
REQ-002 Reset is decided as: reset reset, synchronous, active-high; clock clk.

Function
REQ-003 States and codes SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, WRITE=4, HALT=5, PAUSE=6.
REQ-004 IDLE: on start=1 with prog_mode=0, pc_clr SHALL pulse that cycle and the next state SHALL be FETCH.
REQ-005 FETCH: opcode SHALL be latched into an internal ir; next state DECODE. All later decoding SHALL use ir only.
REQ-006 DECODE: ir=0000 (HLT) SHALL go to HALT; any other opcode SHALL go to EXEC.
REQ-007 alu_s/alu_m/alu_cn SHALL be driven from ir in DECODE, EXEC and WRITE:
- ADD 1001/0/0
- SUB 0110/0/1
- STO, OUT 0000/0/1
- LD, LDV, INP 1010/1/0
- AND 1110/1/0
- OR 1011/1/0
- NOT 0000/1/0
- all other opcodes, and all other states: 0000/0/1
REQ-008 b_sel SHALL be driven the same way: 1 for ADD, SUB, LD, AND, OR; 2 for LDV; 3 for INP; 0 otherwise.
REQ-009 EXEC: alureg_we SHALL pulse for INP, ADD, SUB, LD, LDV, AND, OR, NOT; next state WRITE.
REQ-010 WRITE strobes:
- acc_we SHALL pulse for the same opcode set as alureg_we.
- ram_we SHALL pulse for STO.
- out_we SHALL pulse for OUT.
REQ-011 WRITE PC update:
- pc_load SHALL pulse for B (0101), or for BZ (0110) when acc_zero=1 in WRITE.
- pc_inc SHALL pulse in all other cases.
- pc_load and pc_inc SHALL never both be high.
REQ-012 Opcodes 1101–1111 SHALL produce no write strobes, pc_inc in WRITE, and illegal=1 for that WRITE cycle.
REQ-013 WRITE SHALL go to FETCH. A non-branch instruction therefore takes 4 cycles, FETCH to FETCH.
REQ-014 PC wrap 1111→0000 is the PC's concern; the sequencer SHALL keep issuing pc_inc at address 15.
REQ-015 HALT: no strobes; halted=1. start SHALL pulse pc_clr and go to FETCH.
REQ-016 prog_mode=1 SHALL force IDLE at the next edge from any state, with all strobes low in that cycle. prog_mode SHALL win over a simultaneous start.
REQ-017 At most one of pc_clr, pc_inc, pc_load SHALL be high in any cycle. All strobes SHALL be low in IDLE.

Reset
REQ-018 reset SHALL set state=IDLE and ir=0000. Outputs in the cycle after reset:
- all strobes low
- busy=0, halted=0, illegal=0
- alu_s=0000, alu_m=0, alu_cn=1, b_sel=0
REQ-019 Reset asserted mid-instruction SHALL suppress every strobe in that cycle. reset SHALL override start and prog_mode.

Configuration
REQ-020 With macro CPU_SEQ_STEP_EN defined:
- Inputs step_mode and step SHALL exist.
- When step_mode=1, WRITE SHALL go to PAUSE instead of FETCH.
- PAUSE SHALL go to FETCH on step=1, with no strobes while waiting.
- prog_mode SHALL exit PAUSE to IDLE.
REQ-021 Without CPU_SEQ_STEP_EN, ports step_mode and step SHALL be absent and PAUSE SHALL be unreachable.

Verification
REQ-022 Reset, then start: pc_clr=1 in IDLE; state sequence 1,2,3,4,1. With opcode=0001, alureg_we in EXEC, acc_we and pc_inc in WRITE, alu_s=1001/M0/Cn0, b_sel=1.
REQ-023 Opcode=0110 with acc_zero=1 -> pc_load=1, pc_inc=0 in WRITE. Repeat with acc_zero=0 -> pc_inc=1, pc_load=0.
REQ-024 Opcode=0000 after start -> DECODE then HALT with halted=1 and no strobes for 10 cycles. start -> pc_clr=1 and next state FETCH.
REQ-025 Opcode=1110 -> illegal=1 and pc_inc=1 in WRITE, no write strobes. Opcode=0011 -> ram_we=1 and alu_s=0000/M0/Cn1.
REQ-026 prog_mode=1 asserted in EXEC -> IDLE next cycle, no acc_we ever issued. Reset in WRITE -> IDLE, no strobes.
REQ-027 With CPU_SEQ_STEP_EN and step_mode=1 -> PAUSE after WRITE, held for 5 cycles. step pulse -> FETCH on the next cycle.
